// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that lets NREQ producers share one synchronous FIFO
// write port. The winner holds the port for up to BURST beats or until it drops
// valid. The grant then rotates, starting the search just after the last owner.
module fifo_wr_arb #(
  parameter int DW    = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DW-1:0]             fifo_din,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg;
  logic [IW-1:0]   grant_id_reg;
  logic [IW-1:0]   last_id_reg;
  logic [3:0]      beat_cnt_reg;
  logic            busy_reg;

  logic [IW-1:0]   next_id;
  logic            any_valid;
  logic [DW-1:0]   data_arr [NREQ];

  // Unpack the flat data bus and build the one-hot ready vector per requester.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign data_arr[gi]  = req_data[gi*DW +: DW];
    assign req_ready[gi] = busy_reg & (grant_id_reg == IW'(gi)) & ~fifo_full;
  end

  // Round-robin search: first valid requester after last_id, wrapping mod NREQ.
  // Iterating from the farthest candidate down lets the nearest one win.
  always_comb begin
    next_id   = '0;
    any_valid = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(last_id_reg) + k) % NREQ]) begin
        next_id   = IW'((int'(last_id_reg) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  // Arbitration FSM: IDLE picks a winner, GRANT counts beats and releases on
  // a full burst or when the owner drops valid. A full FIFO only stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      beat_cnt_reg <= '0;
      last_id_reg  <= IW'(NREQ - 1);
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          beat_cnt_reg <= '0;
          if (any_valid) begin
            grant_id_reg <= next_id;
            state_reg    <= GRANT;
            busy_reg     <= 1'b1;
          end
        end
        GRANT: begin
          if (!req_valid[grant_id_reg]) begin
            last_id_reg <= grant_id_reg;
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
          end else if (!fifo_full) begin
            beat_cnt_reg <= beat_cnt_reg + 4'd1;
            if (beat_cnt_reg == 4'(BURST - 1)) begin
              last_id_reg <= grant_id_reg;
              state_reg   <= IDLE;
              busy_reg    <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Write port is combinational from the current owner so a full flag blocks
  // the write in the same cycle it is seen.
  always_comb begin
    fifo_wen = busy_reg & req_valid[grant_id_reg] & ~fifo_full;
    fifo_din = busy_reg ? data_arr[grant_id_reg] : '0;
  end

  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;

endmodule
